// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants for the PS/2 Set-2 scancode decoder: key indices, prefix codes,
// FSM encoding and the LUT result payload.
package ps2_scancode_decoder_pkg;

  localparam int unsigned NUM_KEYS  = 29;
  localparam int unsigned KEY_IDX_W = 5;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Bit positions inside key_state
  localparam logic [KEY_IDX_W-1:0] KEY_TILDE     = 5'd0;
  localparam logic [KEY_IDX_W-1:0] KEY_1         = 5'd1;
  localparam logic [KEY_IDX_W-1:0] KEY_2         = 5'd2;
  localparam logic [KEY_IDX_W-1:0] KEY_3         = 5'd3;
  localparam logic [KEY_IDX_W-1:0] KEY_4         = 5'd4;
  localparam logic [KEY_IDX_W-1:0] KEY_5         = 5'd5;
  localparam logic [KEY_IDX_W-1:0] KEY_6         = 5'd6;
  localparam logic [KEY_IDX_W-1:0] KEY_7         = 5'd7;
  localparam logic [KEY_IDX_W-1:0] KEY_8         = 5'd8;
  localparam logic [KEY_IDX_W-1:0] KEY_9         = 5'd9;
  localparam logic [KEY_IDX_W-1:0] KEY_0         = 5'd10;
  localparam logic [KEY_IDX_W-1:0] KEY_MINUS     = 5'd11;
  localparam logic [KEY_IDX_W-1:0] KEY_EQUALS    = 5'd12;
  localparam logic [KEY_IDX_W-1:0] KEY_BACKSPACE = 5'd13;
  localparam logic [KEY_IDX_W-1:0] KEY_TAB       = 5'd14;
  localparam logic [KEY_IDX_W-1:0] KEY_Q         = 5'd15;
  localparam logic [KEY_IDX_W-1:0] KEY_W         = 5'd16;
  localparam logic [KEY_IDX_W-1:0] KEY_E         = 5'd17;
  localparam logic [KEY_IDX_W-1:0] KEY_R         = 5'd18;
  localparam logic [KEY_IDX_W-1:0] KEY_T         = 5'd19;
  localparam logic [KEY_IDX_W-1:0] KEY_Y         = 5'd20;
  localparam logic [KEY_IDX_W-1:0] KEY_U         = 5'd21;
  localparam logic [KEY_IDX_W-1:0] KEY_I         = 5'd22;
  localparam logic [KEY_IDX_W-1:0] KEY_O         = 5'd23;
  localparam logic [KEY_IDX_W-1:0] KEY_P         = 5'd24;
  localparam logic [KEY_IDX_W-1:0] KEY_LBRACKET  = 5'd25;
  localparam logic [KEY_IDX_W-1:0] KEY_RBRACKET  = 5'd26;
  localparam logic [KEY_IDX_W-1:0] KEY_BACKSLASH = 5'd27;
  localparam logic [KEY_IDX_W-1:0] KEY_SPACEBAR  = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_e;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_lookup_t;

  function automatic logic [KEY_IDX_W-1:0] count_keys(input logic [NUM_KEYS-1:0] keys);
    logic [KEY_IDX_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      n = n + KEY_IDX_W'(keys[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational Set-2 make-code lookup: maps a byte to {hit, key index}.
module ps2_scancode_lut
  import ps2_scancode_decoder_pkg::*;
(
  input  logic [7:0]  code_i,
  output key_lookup_t key_o
);

  always_comb begin
    key_o.hit = 1'b1;
    key_o.idx = '0;
    case (code_i)
      8'h0E:   key_o.idx = KEY_TILDE;
      8'h16:   key_o.idx = KEY_1;
      8'h1E:   key_o.idx = KEY_2;
      8'h26:   key_o.idx = KEY_3;
      8'h25:   key_o.idx = KEY_4;
      8'h2E:   key_o.idx = KEY_5;
      8'h36:   key_o.idx = KEY_6;
      8'h3D:   key_o.idx = KEY_7;
      8'h3E:   key_o.idx = KEY_8;
      8'h46:   key_o.idx = KEY_9;
      8'h45:   key_o.idx = KEY_0;
      8'h4E:   key_o.idx = KEY_MINUS;
      8'h55:   key_o.idx = KEY_EQUALS;
      8'h66:   key_o.idx = KEY_BACKSPACE;
      8'h0D:   key_o.idx = KEY_TAB;
      8'h15:   key_o.idx = KEY_Q;
      8'h1D:   key_o.idx = KEY_W;
      8'h24:   key_o.idx = KEY_E;
      8'h2D:   key_o.idx = KEY_R;
      8'h2C:   key_o.idx = KEY_T;
      8'h35:   key_o.idx = KEY_Y;
      8'h3C:   key_o.idx = KEY_U;
      8'h43:   key_o.idx = KEY_I;
      8'h44:   key_o.idx = KEY_O;
      8'h4D:   key_o.idx = KEY_P;
      8'h54:   key_o.idx = KEY_LBRACKET;
      8'h5B:   key_o.idx = KEY_RBRACKET;
      8'h5D:   key_o.idx = KEY_BACKSLASH;
      8'h29:   key_o.idx = KEY_SPACEBAR;
      default: key_o.hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 decoder: prefix FSM, held-key vector and press/release pulses.
// Define PS2_TYPEMATIC_EN to pulse key_press_pulse on typematic repeats.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 clear_all,
  output logic [NUM_KEYS-1:0]  key_state,
  output logic                 key_press_pulse,
  output logic                 key_release_pulse,
  output logic [KEY_IDX_W-1:0] event_key,
  output logic [KEY_IDX_W-1:0] held_count,
  output logic                 prefix_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]  keys_q, keys_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic [KEY_IDX_W-1:0] evt_q, evt_d;
  logic [KEY_IDX_W-1:0] held_q, held_d;
  logic                 tmo_q, tmo_d;
  key_lookup_t          lut_key;

  ps2_scancode_lut u_lut (
    .code_i (rx_data),
    .key_o  (lut_key)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      keys_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      evt_q     <= '0;
      held_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      press_q   <= press_d;
      release_q <= release_d;
      evt_q     <= evt_d;
      held_q    <= held_d;
      tmo_q     <= tmo_d;
    end
  end

  // Priority: clear_all, then a received byte, then the prefix timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    keys_d    = keys_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    evt_d     = evt_q;
    tmo_d     = 1'b0;

    if (clear_all) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      keys_d  = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (lut_key.hit) begin
            if (!keys_q[lut_key.idx]) begin
              keys_d[lut_key.idx] = 1'b1;
              press_d             = 1'b1;
              evt_d               = lut_key.idx;
            end
`ifdef PS2_TYPEMATIC_EN
            else begin
              press_d = 1'b1;
              evt_d   = lut_key.idx;
            end
`endif
          end
        end
        ST_BREAK: begin
          if (rx_data == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            if (lut_key.hit && keys_q[lut_key.idx]) begin
              keys_d[lut_key.idx] = 1'b0;
              release_d           = 1'b1;
              evt_d               = lut_key.idx;
            end
          end
        end
        // Extended keys are all unmapped, so E0 sequences never touch key state.
        ST_EXT:       state_d = (rx_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        ST_EXT_BREAK: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    held_d = count_keys(keys_d);
  end

  assign key_state         = keys_q;
  assign key_press_pulse   = press_q;
  assign key_release_pulse = release_q;
  assign event_key         = evt_q;
  assign held_count        = held_q;
  assign prefix_timeout    = tmo_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed byte streams, a
// key-table reference model compared every cycle, plus literal spot checks.
module tb_ps2_scancode_decoder;

  localparam int unsigned NK = 29;
  localparam int unsigned TO = 1200;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear_all;
  logic [NK-1:0] key_state;
  logic          key_press_pulse;
  logic          key_release_pulse;
  logic [4:0]    event_key;
  logic [4:0]    held_count;
  logic          prefix_timeout;

  int errors = 0;
  int checks = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50          (clk),
    .resetn            (resetn),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .clear_all         (clear_all),
    .key_state         (key_state),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse),
    .event_key         (event_key),
    .held_count        (held_count),
    .prefix_timeout    (prefix_timeout)
  );

  always #5 clk = ~clk;

  // Make codes in key_state bit order.
  logic [7:0] key_codes [NK] = '{
    8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29
  };

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < int'(NK); i++) begin
      if (key_codes[i] == b) return i;
    end
    return -1;
  endfunction

  // Reference model: pending-prefix flags and idle cycles spent waiting on them.
  logic          m_brk, m_ext;
  int            m_wait;
  logic [NK-1:0] m_held;
  logic          m_press, m_rel, m_tmo;
  int            m_evt;

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = lookup(b);
    if (!m_brk && !m_ext) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (k >= 0) begin
        if (!m_held[k]) begin
          m_held[k] = 1'b1;
          m_press = 1'b1;
          m_evt = k;
        end else begin
`ifdef PS2_TYPEMATIC_EN
          m_press = 1'b1;
          m_evt = k;
`endif
        end
      end
    end else if (m_brk && !m_ext) begin
      if (b == 8'hE0) begin
        m_brk = 1'b0;
        m_ext = 1'b1;
      end else if (b != 8'hF0) begin
        m_brk = 1'b0;
        if (k >= 0 && m_held[k]) begin
          m_held[k] = 1'b0;
          m_rel = 1'b1;
          m_evt = k;
        end
      end
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else m_ext = 1'b0;
    end else begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_brk = 1'b0; m_ext = 1'b0; m_wait = 0; m_held = '0;
      m_press = 1'b0; m_rel = 1'b0; m_tmo = 1'b0; m_evt = 0;
    end else begin
      m_press = 1'b0; m_rel = 1'b0; m_tmo = 1'b0;
      if (clear_all) begin
        m_held = '0; m_brk = 1'b0; m_ext = 1'b0; m_wait = 0;
      end else if (rx_valid) begin
        m_wait = 0;
        model_byte(rx_data);
      end else if (m_brk || m_ext) begin
        m_wait++;
        if (m_wait == int'(TO)) begin
          m_brk = 1'b0; m_ext = 1'b0; m_wait = 0; m_tmo = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model key_state", 32'(key_state), 32'(m_held));
    chk("model press", 32'(key_press_pulse), 32'(m_press));
    chk("model release", 32'(key_release_pulse), 32'(m_rel));
    chk("model event_key", 32'(event_key), 32'(m_evt));
    chk("model held_count", 32'(held_count), 32'($countones(m_held)));
    chk("model timeout", 32'(prefix_timeout), 32'(m_tmo));
  end

  task automatic expect_now(input string name, input logic [NK-1:0] keys, input logic prs,
                            input logic rel, input int evt, input int held, input logic tmo);
    @(negedge clk);
    chk({name, " keys"}, 32'(key_state), 32'(keys));
    chk({name, " press"}, 32'(key_press_pulse), 32'(prs));
    chk({name, " release"}, 32'(key_release_pulse), 32'(rel));
    chk({name, " event"}, 32'(event_key), 32'(evt));
    chk({name, " held"}, 32'(held_count), 32'(held));
    chk({name, " timeout"}, 32'(prefix_timeout), 32'(tmo));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_clear(input logic [7:0] b, input logic with_byte);
    rx_data = b; rx_valid = with_byte; clear_all = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'h00; clear_all = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic TYPE_EN =
`ifdef PS2_TYPEMATIC_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; clear_all = 1'b0;
    repeat (3) @(posedge clk); #1;
    expect_now("reset", '0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    send(8'h15);  expect_now("press Q", 29'h0000_8000, 1, 0, 15, 1, 0);
    idle(1);      expect_now("press Q ends", 29'h0000_8000, 0, 0, 15, 1, 0);
    send(8'hF0);  expect_now("F0 alone", 29'h0000_8000, 0, 0, 15, 1, 0);
    idle(1000);
    send(8'h15);  expect_now("release Q", '0, 0, 1, 15, 0, 0);

    send(8'h29);  expect_now("press space", 29'h1000_0000, 1, 0, 28, 1, 0);
    send(8'h1C);  expect_now("unmapped 1C", 29'h1000_0000, 0, 0, 28, 1, 0);
    send(8'h16);  expect_now("press 1", 29'h1000_0002, 1, 0, 1, 2, 0);
    send(8'h16);  expect_now("repeat 1", 29'h1000_0002, TYPE_EN, 0, 1, 2, 0);

    send(8'hE0); send(8'hF0); send(8'h29);
    expect_now("E0 F0 29", 29'h1000_0002, 0, 0, 1, 2, 0);
    send(8'hF0); send(8'h29);
    expect_now("release space", 29'h0000_0002, 0, 1, 28, 1, 0);

    send(8'hF0); idle(int'(TO) - 1);
    expect_now("expiry cycle", 29'h0000_0002, 0, 0, 28, 1, 0);
    idle(1);     expect_now("timeout pulse", 29'h0000_0002, 0, 0, 28, 1, 1);
    send(8'h15); expect_now("press after tmo", 29'h0000_8002, 1, 0, 15, 2, 0);

    send(8'hF0); idle(int'(TO) - 1);
    send(8'h15); expect_now("byte wins expiry", 29'h0000_0002, 0, 1, 15, 1, 0);
    idle(1);     expect_now("no late tmo", 29'h0000_0002, 0, 0, 15, 1, 0);

    send(8'hF0);
    resetn = 1'b0; idle(2);
    expect_now("mid-prefix reset", '0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    send(8'h16); expect_now("fresh after reset", 29'h0000_0002, 1, 0, 1, 1, 0);

    send(8'h0E); expect_now("press tilde", 29'h0000_0003, 1, 0, 0, 2, 0);
    send(8'h29); expect_now("hold 3", 29'h1000_0003, 1, 0, 28, 3, 0);
    send_clear(8'h0E, 1'b1);
    expect_now("clear wins", '0, 0, 0, 28, 0, 0);
    send(8'h0E); expect_now("tilde after clear", 29'h0000_0001, 1, 0, 0, 1, 0);

    send(8'hF0); send_clear(8'h00, 1'b0);
    send(8'h16); expect_now("clear ends prefix", 29'h0000_0002, 1, 0, 1, 1, 0);

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
